// File: rtl/bp_fe_pkg.sv
// Front-end command definitions shared by the command sequencer and its bench.
package bp_fe_pkg;

  localparam int vaddr_width_p           = 39;
  localparam int fe_cmd_operand_width_lp = 24;

  typedef enum logic [3:0] {
    e_op_state_reset          = 4'd0,
    e_op_pc_redirection       = 4'd1,
    e_op_icache_fill_response = 4'd2,
    e_op_icache_fence         = 4'd3,
    e_op_itlb_fill_response   = 4'd4,
    e_op_itlb_fence           = 4'd5,
    e_op_attaboy              = 4'd6,
    e_op_wait                 = 4'd7
  } bp_fe_command_queue_opcodes_e;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e         opcode;
    logic [vaddr_width_p-1:0]             vaddr;
    logic [fe_cmd_operand_width_lp-1:0]   operands;
  } bp_fe_cmd_s;

  localparam int fe_cmd_width_lp = $bits(bp_fe_cmd_s);

  typedef enum logic [1:0] {
    e_pass,
    e_drain,
    e_fence_wait
  } bp_fe_cmd_seq_state_e;

  // Fences must wait for the fetch pipeline to empty before being forwarded.
  function automatic logic bp_fe_cmd_is_fence(input bp_fe_command_queue_opcodes_e opcode);
    return (opcode == e_op_icache_fence) || (opcode == e_op_itlb_fence);
  endfunction

endpackage

// File: rtl/bp_fe_inflight_counter.sv
// Tracks fetches between I$ acceptance and IF2 exit; saturating up/down counter.
module bp_fe_inflight_counter
#(
  parameter int max_inflight_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int width_lp = $clog2(max_inflight_p + 1);
  localparam logic [width_lp-1:0] max_lp = width_lp'(max_inflight_p);

  logic [width_lp-1:0] count_q, count_d;

  // Simultaneous issue and retire cancel; the count clamps at both ends.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != max_lp)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

  overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(inc_i && !dec_i && (count_q == max_lp)));

  underflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/bp_fe_cmd_sequencer.sv
// One-entry FE command buffer between the BE command FIFO and pc_gen.
// Fences hold off fetch, drain in-flight fetches and wait for I$ idle before
// being forwarded; icache fences additionally wait for fence completion.
module bp_fe_cmd_sequencer
  import bp_fe_pkg::*;
#(
  parameter int max_inflight_p  = 2,
  parameter int fence_timeout_p = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [fe_cmd_width_lp-1:0] be_cmd_i,
  input  logic                       be_cmd_v_i,
  output logic                       be_cmd_yumi_o,
  output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
  output logic                       fe_cmd_v_o,
  input  logic                       fe_cmd_yumi_i,
  input  logic                       fetch_issue_i,
  input  logic                       fetch_retire_i,
  input  logic                       icache_busy_i,
  input  logic                       fence_done_i,
  output logic                       fetch_hold_o,
  output logic                       timeout_o
);

  localparam int tcnt_width_lp = (fence_timeout_p > 2) ? $clog2(fence_timeout_p) : 1;
  localparam logic [tcnt_width_lp-1:0] tcnt_last_lp = tcnt_width_lp'(fence_timeout_p - 1);

  bp_fe_cmd_seq_state_e      state_q, state_d;
  bp_fe_cmd_s                cmd_q, cmd_d;
  logic                      cmd_v_q, cmd_v_d;
  logic [tcnt_width_lp-1:0]  tcnt_q, tcnt_d;
  logic                      timeout_q, timeout_d;

  logic inflight_zero;
  logic head_is_fence, head_is_icache_fence;
  logic fe_v_raw, hold_raw;
  logic deq, enq;

  bp_fe_inflight_counter #(
    .max_inflight_p(max_inflight_p)
  ) u_inflight (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (fetch_issue_i),
    .dec_i     (fetch_retire_i),
    .zero_o    (inflight_zero)
  );

  assign head_is_fence        = bp_fe_cmd_is_fence(cmd_q.opcode);
  assign head_is_icache_fence = (cmd_q.opcode == e_op_icache_fence);

  // Per-state output decode and next-state selection.
  always_comb begin
    fe_v_raw = 1'b0;
    hold_raw = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      e_pass: begin
        if (cmd_v_q) begin
          if (head_is_fence) begin
            hold_raw = 1'b1;
            state_d  = e_drain;
          end else begin
            fe_v_raw = 1'b1;
          end
        end
      end
      e_drain: begin
        hold_raw = 1'b1;
        fe_v_raw = cmd_v_q & inflight_zero & ~icache_busy_i;
        if (fe_v_raw && fe_cmd_yumi_i) begin
          state_d = head_is_icache_fence ? e_fence_wait : e_pass;
        end
      end
      e_fence_wait: begin
        hold_raw = 1'b1;
        if (fence_done_i) begin
          state_d = e_pass;
        end
      end
      default: begin
        state_d = e_pass;
      end
    endcase
  end

  assign fe_cmd_v_o    = reset_n_i & fe_v_raw;
  assign fetch_hold_o  = reset_n_i & hold_raw;
  assign deq           = fe_cmd_v_o & fe_cmd_yumi_i;
  assign be_cmd_yumi_o = reset_n_i & be_cmd_v_i & (~cmd_v_q | deq);
  assign enq           = be_cmd_yumi_o;
  assign fe_cmd_o      = cmd_q;
  assign timeout_o     = timeout_q;

  // Buffer occupancy: a refill in the dequeue cycle keeps the entry valid.
  always_comb begin
    cmd_v_d = cmd_v_q;
    cmd_d   = cmd_q;
    if (enq) begin
      cmd_v_d = 1'b1;
      cmd_d   = bp_fe_cmd_s'(be_cmd_i);
    end else if (deq) begin
      cmd_v_d = 1'b0;
    end
  end

  // Fence-wait watchdog: counts only while waiting and parks at the last value.
  always_comb begin
    tcnt_d    = '0;
    timeout_d = timeout_q;
    if (state_q == e_fence_wait) begin
      if (tcnt_q == tcnt_last_lp) begin
        tcnt_d    = tcnt_q;
        timeout_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // Control state with synchronous reset; reset discards any held command.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= e_pass;
      cmd_v_q   <= 1'b0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_v_q   <= cmd_v_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Command payload needs no reset; its valid bit qualifies it.
  always_ff @(posedge clk_i) begin
    cmd_q <= cmd_d;
  end

endmodule

// File: tb/tb_bp_fe_cmd_sequencer.sv
// Bench for the FE command sequencer: directed scenarios plus a randomized
// run against a queue-based model of in-order delivery and fence rules.
module tb_bp_fe_cmd_sequencer;
  import bp_fe_pkg::*;

  localparam int MaxInflight  = 2;
  localparam int FenceTimeout = 16;

  logic                       clk = 1'b0;
  logic                       resetN;
  logic [fe_cmd_width_lp-1:0] beCmd;
  logic                       beCmdV;
  logic                       beCmdYumi;
  logic [fe_cmd_width_lp-1:0] feCmd;
  logic                       feCmdV;
  logic                       feCmdYumi;
  logic                       fetchIssue;
  logic                       fetchRetire;
  logic                       icacheBusy;
  logic                       fenceDone;
  logic                       fetchHold;
  logic                       timeoutFlag;

  int nChecks = 0;
  int nFails  = 0;

  bp_fe_cmd_s sendQ[$];
  bp_fe_cmd_s bufQ[$];
  int         mInflight;
  int         fenceAge;
  int         doneDelay;
  int         delivered;
  int         totalSent;
  int         cycleNo;
  bit         mWaitDone;
  bit         lastHold;

  always #5 clk = ~clk;

  bp_fe_cmd_sequencer #(
    .max_inflight_p  (MaxInflight),
    .fence_timeout_p (FenceTimeout)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .be_cmd_i       (beCmd),
    .be_cmd_v_i     (beCmdV),
    .be_cmd_yumi_o  (beCmdYumi),
    .fe_cmd_o       (feCmd),
    .fe_cmd_v_o     (feCmdV),
    .fe_cmd_yumi_i  (feCmdYumi),
    .fetch_issue_i  (fetchIssue),
    .fetch_retire_i (fetchRetire),
    .icache_busy_i  (icacheBusy),
    .fence_done_i   (fenceDone),
    .fetch_hold_o   (fetchHold),
    .timeout_o      (timeoutFlag)
  );

  function automatic bp_fe_cmd_s mkCmd(input bp_fe_command_queue_opcodes_e op,
                                       input logic [vaddr_width_p-1:0] va);
    bp_fe_cmd_s c;
    c.opcode   = op;
    c.vaddr    = va;
    c.operands = 24'h5A5A5A;
    return c;
  endfunction

  function automatic bit isFenceOp(input bp_fe_command_queue_opcodes_e op);
    return (op == e_op_icache_fence) || (op == e_op_itlb_fence);
  endfunction

  task automatic applyStimulus(input bit beV, input bp_fe_cmd_s cmd, input bit feY,
                               input bit issue, input bit retire, input bit busy,
                               input bit done);
    beCmdV      = beV;
    beCmd       = cmd;
    feCmdYumi   = feY;
    fetchIssue  = issue;
    fetchRetire = retire;
    icacheBusy  = busy;
    fenceDone   = done;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    applyStimulus(1'b1, mkCmd(e_op_attaboy, 39'h40), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) nextCycle();
    @(negedge clk);
    nChecks++;
    if ({beCmdYumi, feCmdV, fetchHold} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL reset_gating {yumi,v,hold} got %b expected 000", {beCmdYumi, feCmdV, fetchHold});
    end
    nChecks++;
    if (timeoutFlag !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_timeout got %b expected 0", timeoutFlag);
    end
    nextCycle();
    resetN = 1'b1;
    applyStimulus(1'b0, mkCmd(e_op_attaboy, 39'h40), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    nChecks++;
    if ({beCmdYumi, feCmdV, fetchHold, timeoutFlag} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reset_release {yumi,v,hold,timeout} got %b expected 0000",
               {beCmdYumi, feCmdV, fetchHold, timeoutFlag});
    end
  endtask

  task automatic test_attaboy();
    logic [2:0] expSeq [3] = '{3'b100, 3'b010, 3'b000};
    bp_fe_cmd_s ab = mkCmd(e_op_attaboy, 39'h123);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      applyStimulus(k == 0, ab, k != 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expSeq[k]) begin
        nFails++;
        $display("[TB] FAIL attaboy cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expSeq[k]);
      end
      if (k == 1) begin
        nChecks++;
        if (feCmd !== ab) begin
          nFails++;
          $display("[TB] FAIL attaboy_data got %h expected %h", feCmd, ab);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] expSeq [4] = '{3'b100, 3'b110, 3'b010, 3'b000};
    bp_fe_cmd_s ra = mkCmd(e_op_pc_redirection, 39'h1000);
    bp_fe_cmd_s rb = mkCmd(e_op_pc_redirection, 39'h2000);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(k < 2, (k == 0) ? ra : rb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expSeq[k]) begin
        nFails++;
        $display("[TB] FAIL back_to_back cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expSeq[k]);
      end
      if (k == 1 || k == 2) begin
        nChecks++;
        if (feCmd !== ((k == 1) ? ra : rb)) begin
          nFails++;
          $display("[TB] FAIL back_to_back_data cycle %0d got %h expected %h",
                   k, feCmd, (k == 1) ? ra : rb);
        end
      end
    end
  endtask

  task automatic test_itlb_fence();
    logic [2:0] expSeq [10] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001,
                                3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
    bp_fe_cmd_s fence = mkCmd(e_op_itlb_fence, 39'h0);
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      applyStimulus(k == 2, fence, 1'b1, k < 2, (k == 5) || (k == 7), 1'b0, 1'b0);
      @(negedge clk);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expSeq[k]) begin
        nFails++;
        $display("[TB] FAIL itlb_fence cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expSeq[k]);
      end
      if (k == 8) begin
        nChecks++;
        if (feCmd !== fence) begin
          nFails++;
          $display("[TB] FAIL itlb_fence_data got %h expected %h", feCmd, fence);
        end
      end
    end
  endtask

  task automatic test_icache_fence();
    logic [2:0] expSeq [10] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b111,
                                3'b001, 3'b001, 3'b001, 3'b010, 3'b000};
    bp_fe_cmd_s fence = mkCmd(e_op_icache_fence, 39'h0);
    bp_fe_cmd_s redir = mkCmd(e_op_pc_redirection, 39'h3000);
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      applyStimulus(k <= 4, (k == 0) ? fence : redir, 1'b1, 1'b0, 1'b0,
                    (k >= 1) && (k <= 3), (k == 2) || (k == 7));
      @(negedge clk);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expSeq[k]) begin
        nFails++;
        $display("[TB] FAIL icache_fence cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expSeq[k]);
      end
      if (k == 4 || k == 8) begin
        nChecks++;
        if (feCmd !== ((k == 4) ? fence : redir)) begin
          nFails++;
          $display("[TB] FAIL icache_fence_data cycle %0d got %h expected %h",
                   k, feCmd, (k == 4) ? fence : redir);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] expOut;
    bit expTimeout;
    bp_fe_cmd_s fence = mkCmd(e_op_icache_fence, 39'h0);
    bp_fe_cmd_s redir = mkCmd(e_op_pc_redirection, 39'h4000);
    for (int k = 0; k < 29; k++) begin
      nextCycle();
      resetN = (k != 26);
      applyStimulus((k <= 2) || (k == 26), (k == 0) ? fence : redir, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 0)       expOut = 3'b100;
      else if (k == 1)  expOut = 3'b001;
      else if (k == 2)  expOut = 3'b111;
      else if (k <= 25) expOut = 3'b001;
      else              expOut = 3'b000;
      expTimeout = (k >= 19) && (k <= 26);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expOut) begin
        nFails++;
        $display("[TB] FAIL timeout_seq cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expOut);
      end
      nChecks++;
      if (timeoutFlag !== expTimeout) begin
        nFails++;
        $display("[TB] FAIL timeout_flag cycle %0d got %b expected %b", k, timeoutFlag, expTimeout);
      end
    end
  endtask

  task automatic test_simul_issue_retire();
    logic [2:0] expSeq [8] = '{3'b000, 3'b100, 3'b001, 3'b001,
                               3'b001, 3'b001, 3'b011, 3'b000};
    bp_fe_cmd_s fence = mkCmd(e_op_itlb_fence, 39'h0);
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      applyStimulus(k == 1, fence, 1'b1, (k == 0) || (k == 3), (k == 3) || (k == 5),
                    1'b0, 1'b0);
      @(negedge clk);
      nChecks++;
      if ({beCmdYumi, feCmdV, fetchHold} !== expSeq[k]) begin
        nFails++;
        $display("[TB] FAIL simul_issue_retire cycle %0d {yumi,v,hold} got %b expected %b",
                 k, {beCmdYumi, feCmdV, fetchHold}, expSeq[k]);
      end
    end
  endtask

  task automatic randCycle(input bit calm);
    bit beV, feY, issue, retire, busy, done;
    bit headFence, expV, expHold, expYumi, deq, oldWait;
    bp_fe_cmd_s cmd, popped;
    nextCycle();
    cycleNo++;
    beV    = (sendQ.size() > 0) && (calm || ($urandom_range(0, 9) < 7));
    cmd    = (sendQ.size() > 0) ? sendQ[0] : mkCmd(e_op_wait, 39'h0);
    feY    = calm || ($urandom_range(0, 3) != 0);
    issue  = !calm && !lastHold && (mInflight < MaxInflight) && ($urandom_range(0, 2) == 0);
    retire = (mInflight > 0) && (calm || ($urandom_range(0, 2) == 0));
    busy   = !calm && ($urandom_range(0, 3) == 0);
    done   = mWaitDone ? (doneDelay == 0) : (!calm && ($urandom_range(0, 15) == 0));
    applyStimulus(beV, cmd, feY, issue, retire, busy, done);
    @(negedge clk);

    headFence = (bufQ.size() > 0) && isFenceOp(bufQ[0].opcode);
    expHold   = headFence || mWaitDone;
    if (mWaitDone || (bufQ.size() == 0)) expV = 1'b0;
    else if (!headFence)                 expV = 1'b1;
    else expV = (fenceAge >= 1) && (mInflight == 0) && !busy;
    expYumi = beV && ((bufQ.size() == 0) || (expV && feY));

    nChecks++;
    if ({beCmdYumi, feCmdV, fetchHold} !== {expYumi, expV, expHold}) begin
      nFails++;
      $display("[TB] FAIL random cycle %0d {yumi,v,hold} got %b expected %b",
               cycleNo, {beCmdYumi, feCmdV, fetchHold}, {expYumi, expV, expHold});
    end
    if (expV) begin
      nChecks++;
      if (feCmd !== bufQ[0]) begin
        nFails++;
        $display("[TB] FAIL random_data cycle %0d got %h expected %h", cycleNo, feCmd, bufQ[0]);
      end
    end

    oldWait = mWaitDone;
    deq     = expV && feY;
    if (oldWait && doneDelay > 0) doneDelay--;
    if (deq) begin
      popped = bufQ.pop_front();
      delivered++;
      if (popped.opcode == e_op_icache_fence) begin
        mWaitDone = 1'b1;
        doneDelay = $urandom_range(0, 6);
      end
    end
    if (oldWait && done) mWaitDone = 1'b0;
    if (expYumi) bufQ.push_back(sendQ.pop_front());
    if (deq || expYumi)             fenceAge = 0;
    else if (headFence && !oldWait) fenceAge++;
    mInflight = mInflight + int'(issue) - int'(retire);
    lastHold  = expHold;
  endtask

  task automatic test_random();
    int guard;
    bp_fe_command_queue_opcodes_e op;
    int r;
    sendQ.delete();
    bufQ.delete();
    mInflight = 0;
    fenceAge  = 0;
    doneDelay = 0;
    delivered = 0;
    mWaitDone = 1'b0;
    lastHold  = 1'b0;
    cycleNo   = 0;
    totalSent = 150;
    for (int i = 0; i < totalSent; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)       op = e_op_icache_fence;
      else if (r == 2) op = e_op_itlb_fence;
      else             op = bp_fe_command_queue_opcodes_e'($urandom_range(0, 7));
      sendQ.push_back(mkCmd(op, {7'($urandom), 32'($urandom)}));
    end
    for (int c = 0; c < 1200; c++) randCycle(1'b0);
    guard = 0;
    while (((sendQ.size() > 0) || (bufQ.size() > 0) || mWaitDone) && (guard < 2000)) begin
      randCycle(1'b1);
      guard++;
    end
    nChecks++;
    if (delivered !== totalSent) begin
      nFails++;
      $display("[TB] FAIL random_delivered got %0d expected %0d", delivered, totalSent);
    end
    nChecks++;
    if (timeoutFlag !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL random_timeout got %b expected 0", timeoutFlag);
    end
  endtask

  initial begin
    test_reset();
    test_attaboy();
    test_back_to_back();
    test_itlb_fence();
    test_icache_fence();
    test_timeout();
    test_simul_issue_retire();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired after %0d checks with %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/bp_fe_cmd_sequencer.md
Name: bp_fe_cmd_sequencer

Overview:
- Sits between the BE-to-FE command FIFO and bp_fe_pc_gen.
- Buffers one FE command and forwards it to pc_gen in order.
- For fence commands (icache_fence, itlb_fence), first holds off new fetches, drains in-flight fetches and waits for the I$ to go idle.
- For icache_fence, also waits for fence completion before releasing fetch. All other opcodes pass through with one cycle of latency.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies vaddr_width_p etc. and fe_cmd_width_lp.
- max_inflight_p, 2, maximum outstanding fetches (pc_gen IF1+IF2 depth).
- fence_timeout_p, 1024, cycles allowed in e_fence_wait before the timeout flag sets.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- be_cmd_i  in  fe_cmd_width_lp  bp_fe_cmd_s from the BE command FIFO.
- be_cmd_v_i  in  1  be_cmd_i valid.
- be_cmd_yumi_o  out  1  command dequeued from the FIFO this cycle.
- fe_cmd_o  out  fe_cmd_width_lp  buffered command to pc_gen.
- fe_cmd_v_o  out  1  fe_cmd_o valid.
- fe_cmd_yumi_i  in  1  pc_gen accepted fe_cmd_o.
- fetch_issue_i  in  1  pulse: pc_gen fetch accepted by I$ (mem_cmd_yumi with op fetch).
- fetch_retire_i  in  1  pulse: fetch left IF2 (response consumed, flushed or poisoned).
- icache_busy_i  in  1  I$ servicing a miss or fill.
- fence_done_i  in  1  pulse: I$ fence complete.
- fetch_hold_o  out  1  pc_gen must not issue new fetches.
- timeout_o  out  1  sticky: fence wait exceeded fence_timeout_p.

Behaviour:
- Reset (reset_n_i=0 at posedge): state=e_pass, cmd_v_r=0, inflight_r=0, timeout counter=0, timeout_o=0. While reset is asserted, be_cmd_yumi_o, fe_cmd_v_o and fetch_hold_o are forced to 0. Reset mid-operation discards any held command.
- Buffer: one entry, cmd_r/cmd_v_r.
  - be_cmd_yumi_o = be_cmd_v_i & (~cmd_v_r | (fe_cmd_v_o & fe_cmd_yumi_i)).
  - Enqueue and dequeue in the same cycle is allowed.
  - Minimum pass-through latency is 1 cycle (registered).
- Fence class = opcode e_op_icache_fence or e_op_itlb_fence. All other opcodes (including attaboy, redirect, state_reset, itlb_fill) are non-fence.
- Inflight counter, width $clog2(max_inflight_p+1):
  - +1 on fetch_issue_i, -1 on fetch_retire_i; both in the same cycle leaves it unchanged.
  - Saturates at 0 and max_inflight_p; under- or overflow triggers a simulation assertion.
- FSM state e_pass:
  - cmd_v_r with a non-fence opcode: fe_cmd_v_o=1, fetch_hold_o=0.
  - cmd_v_r with a fence opcode: fe_cmd_v_o=0, fetch_hold_o=1, next state e_drain.
- FSM state e_drain:
  - fetch_hold_o=1.
  - fe_cmd_v_o = (inflight_r==0) & ~icache_busy_i.
  - On fe_cmd_yumi_i: icache_fence goes to e_fence_wait; itlb_fence goes to e_pass.
  - be_cmd_yumi_o may refill the buffer in the yumi cycle.
- FSM state e_fence_wait:
  - fetch_hold_o=1, fe_cmd_v_o=0.
  - On fence_done_i: go to e_pass.
  - The counter increments each cycle. On reaching fence_timeout_p-1, timeout_o sets and stays set until reset, and the FSM stays in e_fence_wait.
  - fence_done_i outside e_fence_wait is ignored.
- fetch_hold_o is asserted in the same cycle the fence reaches the buffer head, so no new fetch issues after the fence is visible. A fetch_issue_i in that cycle is still counted.
- The command stream stays strictly in order. A non-fence command behind a fence waits in the FIFO (not accepted) until the fence is delivered.
- fe_cmd_o = cmd_r, always driven. pc_gen is required to accept within a cycle, but the sequencer holds fe_cmd_v_o until yumi regardless.

Decomposition:
- Package bp_fe_pkg additions:
  - enum bp_fe_cmd_seq_state_e {e_pass, e_drain, e_fence_wait}.
  - Function bp_fe_cmd_is_fence(opcode).
- Sub-module bp_fe_inflight_counter (up/down saturating counter with zero flag), parameterised by max_inflight_p.
- The FSM and buffer live in the top module.

Test Plan:
- Reset release, then attaboy at cycle 1:
  - be_cmd_yumi_o=1 at cycle 1; fe_cmd_v_o=1 at cycle 2; fetch_hold_o stays 0.
- Back-to-back redirects vaddr 0x1000 then 0x2000, pc_gen yumi every cycle:
  - One command per cycle, in order; no bubbles after the first.
- itlb_fence with inflight=2, retires at cycles +2 and +4:
  - fetch_hold_o=1 immediately; fe_cmd_v_o rises the cycle after inflight reaches 0.
  - Returns to e_pass after yumi.
- icache_fence with inflight=0 and icache_busy_i high for 3 cycles:
  - Forwarded after busy drops; hold stays 1 until fence_done_i; redirect queued behind it is accepted only after the fence yumi.
- icache_fence, fence_done_i never arrives, fence_timeout_p=16:
  - timeout_o=1 after 16 cycles in e_fence_wait; stays set.
  - A later reset_n_i=0 clears it and drops the held cmd.
- Simultaneous fetch_issue_i and fetch_retire_i at inflight=1 during e_drain:
  - Count stays 1; fence not forwarded that cycle.
